// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage and MEM/WB register with a word-addressed data RAM
//   params : ADDR_W (word-address bits, depth 2^ADDR_W x 32), MEM_LAT (extra cycles per load/store, 0..15)
//   in     : clk, rst (sync, active-high), MEM_regwrite, MEM_memtoreg, MEM_memread, MEM_memwrite,
//            MEM_out (ALU result / byte address), MEM_wdata (store data), MEM_rd
//   out    : stall (hold upstream), WB_regwrite, WB_memtoreg, WB_rdata, WB_out, WB_rd, err_misalign
//   macro  : MEM_MISALIGN_CHECK_EN suppresses misaligned accesses and sets sticky err_misalign
module mem_wb_stage #(
  parameter int ADDR_W = 8,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_regwrite,
  input  logic        MEM_memtoreg,
  input  logic        MEM_memread,
  input  logic        MEM_memwrite,
  input  logic [31:0] MEM_out,
  input  logic [31:0] MEM_wdata,
  input  logic [2:0]  MEM_rd,
  output logic        stall,
  output logic        WB_regwrite,
  output logic        WB_memtoreg,
  output logic [31:0] WB_rdata,
  output logic [31:0] WB_out,
  output logic [2:0]  WB_rd,
  output logic        err_misalign
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] ram [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic mem_op, bad, unused;
  assign mem_op = MEM_memread | MEM_memwrite;
  assign idx = MEM_out[ADDR_W+1:2];
  assign unused = ^{MEM_out[31:ADDR_W+2], MEM_out[1:0]};
`ifdef MEM_MISALIGN_CHECK_EN
  assign bad = mem_op & (|MEM_out[1:0]);
  always_ff @(posedge clk)
    err_misalign <= rst ? 1'b0 : err_misalign | (bad & ~stall);
`else
  assign bad = 1'b0;
  assign err_misalign = 1'b0;
`endif
  always_comb stall = (state == IDLE) ? ((MEM_LAT != 0) && mem_op) : (cnt != 4'd0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      WB_regwrite <= 1'b0;
      WB_memtoreg <= 1'b0;
      WB_rdata <= 32'd0;
      WB_out <= 32'd0;
      WB_rd <= 3'd0;
    end else if (stall) begin
      state <= BUSY;
      cnt <= (state == IDLE) ? 4'(MEM_LAT - 1) : cnt - 4'd1;
      WB_regwrite <= 1'b0;
    end else begin
      state <= IDLE;
      WB_regwrite <= MEM_regwrite & ~bad;
      WB_memtoreg <= MEM_memtoreg;
      WB_rdata <= (MEM_memread & ~bad) ? ram[idx] : 32'd0;
      WB_out <= MEM_out;
      WB_rd <= MEM_rd;
    end
  end
  always_ff @(posedge clk)
    if (!rst && !stall && MEM_memwrite && !bad) ram[idx] <= MEM_wdata;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized self-checking bench for mem_wb_stage against a word-array memory model
module tb_mem_wb_stage;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic rw = 0, mt = 0, mr = 0, mw = 0;
  logic [31:0] mo = 0, wd = 0;
  logic [2:0] rd = 0;
  logic stall, wrw, wmt, err;
  logic [31:0] wrdata, wout;
  logic [2:0] wrd;
  logic z_rw = 0, z_mt = 0, z_mr = 0, z_mw = 0;
  logic [31:0] z_mo = 0, z_wd = 0;
  logic [2:0] z_rd = 0;
  logic z_stall, z_wrw, z_wmt, z_err;
  logic [31:0] z_wrdata, z_wout;
  logic [2:0] z_wrd;
  int vectors = 0, miscompares = 0;
  logic [31:0] mem_m [256];
  bit known [256];
  bit err_m = 0;

  mem_wb_stage #(.ADDR_W(8), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .MEM_regwrite(rw), .MEM_memtoreg(mt), .MEM_memread(mr),
    .MEM_memwrite(mw), .MEM_out(mo), .MEM_wdata(wd), .MEM_rd(rd), .stall(stall),
    .WB_regwrite(wrw), .WB_memtoreg(wmt), .WB_rdata(wrdata), .WB_out(wout),
    .WB_rd(wrd), .err_misalign(err));

  mem_wb_stage #(.ADDR_W(8), .MEM_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .MEM_regwrite(z_rw), .MEM_memtoreg(z_mt), .MEM_memread(z_mr),
    .MEM_memwrite(z_mw), .MEM_out(z_mo), .MEM_wdata(z_wd), .MEM_rd(z_rd), .stall(z_stall),
    .WB_regwrite(z_wrw), .WB_memtoreg(z_wmt), .WB_rdata(z_wrdata), .WB_out(z_wout),
    .WB_rd(z_wrd), .err_misalign(z_err));

  task automatic model(input logic rw_, rd_, wr_, input logic [31:0] a, w,
                       output logic e_rw, output logic [31:0] e_rdata, output bit e_known);
    int i;
    bit bad_m;
    i = int'((a >> 2) % 256);
    bad_m = 0;
`ifdef MEM_MISALIGN_CHECK_EN
    bad_m = (rd_ || wr_) && (a % 4 != 0);
`endif
    e_rw = rw_ && !bad_m;
    e_rdata = 0;
    e_known = 1;
    if (rd_ && !bad_m) begin
      e_rdata = mem_m[i];
      e_known = known[i];
    end
    if (wr_ && !bad_m) begin
      mem_m[i] = w;
      known[i] = 1;
    end
    if (bad_m) err_m = 1;
  endtask

  task automatic do_op(input logic rw_, mt_, rd_, wr_, input logic [31:0] a, w, input logic [2:0] d);
    logic e_rw;
    logic [31:0] e_rdata;
    bit e_known;
    rw = rw_; mt = mt_; mr = rd_; mw = wr_; mo = a; wd = w; rd = d;
    model(rw_, rd_, wr_, a, w, e_rw, e_rdata, e_known);
    #1;
    if (rd_ || wr_)
      for (int k = 0; k < LAT; k++) begin
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL stall_busy: got %b want 1 (a=%h k=%0d)", stall, a, k); end
        @(posedge clk); #1;
        vectors++;
        if (wrw !== 1'b0) begin miscompares++; $display("FAIL bubble: WB_regwrite got %b want 0", wrw); end
      end
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL stall_last: got %b want 0 (a=%h)", stall, a); end
    @(posedge clk); #1;
    vectors++;
    if (wrw !== e_rw) begin miscompares++; $display("FAIL wb_regwrite: got %b want %b", wrw, e_rw); end
    vectors++;
    if (wmt !== mt_) begin miscompares++; $display("FAIL wb_memtoreg: got %b want %b", wmt, mt_); end
    vectors++;
    if (wout !== a) begin miscompares++; $display("FAIL wb_out: got %h want %h", wout, a); end
    vectors++;
    if (wrd !== d) begin miscompares++; $display("FAIL wb_rd: got %0d want %0d", wrd, d); end
    if (e_known) begin
      vectors++;
      if (wrdata !== e_rdata) begin miscompares++; $display("FAIL wb_rdata: got %h want %h (a=%h)", wrdata, e_rdata, a); end
    end
    vectors++;
    if (err !== err_m) begin miscompares++; $display("FAIL err_misalign: got %b want %b", err, err_m); end
  endtask

  task automatic nop_inputs();
    rw = 0; mt = 0; mr = 0; mw = 0; mo = 0; wd = 0; rd = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    nop_inputs();
    repeat (2) @(posedge clk);
    #1;
    err_m = 0;
    vectors++;
    if ({wrw, wmt, wrdata, wout, wrd} !== '0) begin
      miscompares++; $display("FAIL reset_wb: got %b %b %h %h %0d want all 0", wrw, wmt, wrdata, wout, wrd);
    end
    vectors++;
    if (stall !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL reset_flags: stall=%b err=%b want 0 0", stall, err); end
    rst = 0;
  endtask

  task automatic test_reset_mid();
    do_op(0, 0, 0, 1, 32'h10, 32'h1111_1111, 0);
    rw = 0; mt = 0; mr = 0; mw = 1; mo = 32'h10; wd = 32'h2222_2222; rd = 0;
    @(posedge clk); #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL mid_busy: stall got %b want 1", stall); end
    rst = 1;
    nop_inputs();
    @(posedge clk); #1;
    rst = 0;
    err_m = 0;
    vectors++;
    if (stall !== 1'b0 || {wrw, wmt, wrdata, wout, wrd} !== '0) begin
      miscompares++; $display("FAIL mid_reset: stall=%b wb=%b %b %h %h %0d want all 0", stall, wrw, wmt, wrdata, wout, wrd);
    end
    do_op(1, 1, 1, 0, 32'h10, 0, 2);
  endtask

  task automatic test_alu();
    do_op(1, 0, 0, 0, 32'h1234, $urandom, 5);
    do_op(0, 0, 0, 0, 32'hCAFE_0001, $urandom, 7);
  endtask

  task automatic test_store_load();
    do_op(0, 0, 0, 1, 32'h40, 32'hDEAD_BEEF, 0);
    do_op(1, 1, 1, 0, 32'h40, 0, 3);
  endtask

  task automatic test_wrap();
    do_op(0, 0, 0, 1, 32'h400, 32'hA5A5_A5A5, 0);
    do_op(1, 1, 1, 0, 32'h000, 0, 1);
  endtask

  task automatic test_rw_same();
    do_op(0, 0, 0, 1, 32'h40, 32'h1, 0);
    do_op(1, 1, 1, 1, 32'h40, 32'h2, 4);
    do_op(1, 1, 1, 0, 32'h40, 0, 6);
  endtask

  task automatic test_misalign();
    do_op(0, 0, 0, 1, 32'h41, 32'h77, 0);
    do_op(1, 1, 1, 0, 32'h40, 0, 2);
    do_op(1, 0, 0, 0, 32'h55, 0, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
      do_op(1'($urandom), kind == 1 || kind == 3, kind == 1 || kind == 3, kind >= 2, a, $urandom, 3'($urandom));
    end
  endtask

  task automatic test_lat0();
    z_rw = 0; z_mt = 0; z_mr = 0; z_mw = 1; z_mo = 32'h400; z_wd = 32'hA5A5_A5A5; z_rd = 0;
    #1;
    vectors++;
    if (z_stall !== 1'b0) begin miscompares++; $display("FAIL lat0_store_stall: got %b want 0", z_stall); end
    @(posedge clk); #1;
    z_rw = 1; z_mt = 1; z_mr = 1; z_mw = 0; z_mo = 32'h0; z_rd = 6;
    #1;
    vectors++;
    if (z_stall !== 1'b0) begin miscompares++; $display("FAIL lat0_load_stall: got %b want 0", z_stall); end
    @(posedge clk); #1;
    vectors++;
    if (z_wrdata !== 32'hA5A5_A5A5 || z_wrd !== 3'd6 || z_wrw !== 1'b1) begin
      miscompares++; $display("FAIL lat0_load: rdata=%h rd=%0d rw=%b want a5a5a5a5 6 1", z_wrdata, z_wrd, z_wrw);
    end
    z_mr = 0; z_rw = 0; z_mt = 0;
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_alu();
    test_store_load();
    test_wrap();
    test_rw_same();
    test_misalign();
    test_random();
    test_reset_mid();
    test_lat0();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register for the CPU. It consumes the MEM_* control and data bundle launched by the EX/MEM register. Loads and stores go to a local word-addressed data RAM with a configurable access latency. While the access is in flight it stalls upstream, then launches the WB_* bundle consumed by register-file writeback.

## Interface
- ADDR_W, 8 — word-address bits; RAM depth 2^ADDR_W words of 32 bits
- MEM_LAT, 2 — extra cycles per load/store, legal 0..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- MEM_regwrite  in  1  writeback enable from EX/MEM
- MEM_memtoreg  in  1  select RAM read data for writeback
- MEM_memread  in  1  load request
- MEM_memwrite  in  1  store request
- MEM_out  in  32  ALU result / byte address
- MEM_wdata  in  32  store data
- MEM_rd  in  3  destination register
- stall  out  1  hold EX/MEM and earlier stages this cycle
- WB_regwrite  out  1  registered writeback enable
- WB_memtoreg  out  1  registered memtoreg
- WB_rdata  out  32  registered RAM read data
- WB_out  out  32  registered ALU result
- WB_rd  out  3  registered destination register
- err_misalign  out  1  sticky misaligned-access flag (see Configuration)

## Operation
- Mem op = MEM_memread | MEM_memwrite. Word index = MEM_out[ADDR_W+1:2]. Bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM depth.
- FSM states: IDLE, BUSY. Down-counter cnt is 4 bits.
- IDLE, no mem op:
  - stall=0.
  - Next edge loads WB_* from MEM_* with WB_rdata=0.
- IDLE, mem op, MEM_LAT=0:
  - stall=0.
  - The access commits on the next edge.
- IDLE, mem op, MEM_LAT>0:
  - stall=1.
  - Next edge: cnt<=MEM_LAT-1, go to BUSY, WB_regwrite<=0 (bubble). Other WB_* hold their values.
- BUSY, cnt≠0:
  - stall=1.
  - cnt decrements each edge; bubble written each edge.
- BUSY, cnt=0:
  - stall=0.
  - Next edge commits the access and returns to IDLE.
- Commit edge:
  - Store: RAM[index]<=MEM_wdata.
  - Load: WB_rdata<=RAM[index].
  - Load WB_regwrite, WB_memtoreg, WB_out, WB_rd from MEM_*.
- Read and write asserted together: treated as a store. WB_rdata returns the pre-write word (read-before-write).
- Upstream holds the MEM_* inputs stable while stall=1. The block samples them only at commit.
- RAM contents are not reset.
- rst, including mid-access:
  - State goes to IDLE, cnt=0.
  - A pending store is dropped.
  - WB_regwrite=0, WB_memtoreg=0, WB_rdata=0, WB_out=0, WB_rd=0, err_misalign=0.
  - stall=0 in the cycle following the rst edge.

## Timing
- Non-memory instruction: 1 cycle, MEM_* to WB_*.
- Load/store: occupies MEM_LAT+1 cycles; stall high for exactly MEM_LAT cycles. WB_* is valid on the edge ending the final (stall=0) cycle.
- stall is combinational from state, cnt and MEM_memread/MEM_memwrite. There is no combinational path from MEM_out or MEM_wdata to stall.
- Back-to-back mem ops: the next op's stall is asserted in the cycle immediately after commit. No idle gap.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - A mem op with MEM_out[1:0]≠0 still consumes the full latency.
  - At commit the store is suppressed and WB_rdata<=0.
  - WB_regwrite<=0 and err_misalign<=1. err_misalign is sticky until rst.
- MEM_MISALIGN_CHECK_EN undefined:
  - MEM_out[1:0] is ignored and the access proceeds on the word index.
  - err_misalign is tied to 0.

## Test plan
- Reset: after rst held 2 cycles, all WB_* = 0, stall=0, err_misalign=0. Then assert rst mid-BUSY of a store to 0x10; a later load of 0x10 returns the previously written value, not the dropped one.
- ALU op, MEM_LAT=2: MEM_out=0x1234, MEM_rd=5, MEM_regwrite=1, no mem op -> next edge WB_out=0x1234, WB_rd=5, WB_regwrite=1, stall never high.
- Store then load, MEM_LAT=2: store 0xDEADBEEF to 0x40 -> stall high 2 cycles, commit on 3rd edge. Load 0x40 with rd=3 -> stall 2 cycles, then WB_rdata=0xDEADBEEF, WB_memtoreg=1, WB_rd=3. WB_regwrite=0 on every stall edge.
- Wrap, ADDR_W=8: store 0xA5A5A5A5 to 0x400, load 0x000 -> WB_rdata=0xA5A5A5A5. Same test with MEM_LAT=0 -> no stall cycles.
- Read+write simultaneously at 0x40 (old value 0x1, new value 0x2) -> WB_rdata=0x1, later load returns 0x2.
- With MEM_MISALIGN_CHECK_EN: store 0x77 to 0x41 -> err_misalign=1 after commit, a load of 0x40 is unchanged, and the flag stays set until rst. Without the macro: the same store writes word 0x40 and err_misalign stays 0.
